// File: rtl/tone_symbol_sequencer.sv
// tone_symbol_sequencer: FIFO-fed tone byte player with fixed symbol and gap timing for the 8-tone modulator
module tone_symbol_sequencer #(
    parameter int SYMBOL_CYCLES = 1000000,
    parameter int GAP_CYCLES    = 250000,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [7:0]                    data_out,
    output logic                          carrier_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, SYMBOL = 2'd1, GAP = 2'd2;
    logic [1:0] state;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic push, pop, empty, sym_last, gap_last;
    assign empty    = fifo_count == '0;
    assign in_ready = fifo_count != (AW+1)'(FIFO_DEPTH);
    assign busy     = state != IDLE || !empty;
    assign push     = in_valid && in_ready;
    assign sym_last = cnt == CNT_W'(SYMBOL_CYCLES - 1);
    assign gap_last = cnt == CNT_W'(GAP_CYCLES - 1);
    assign pop      = !empty && (state == IDLE || (state == SYMBOL && sym_last && GAP_CYCLES == 0)
                                               || (state == GAP && gap_last));
    always_ff @(posedge clk)
        if (push && rst && !flush) mem[wr_ptr] <= in_data;
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            cnt        <= '0;
            data_out   <= 8'h00;
            carrier_en <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            // Any pop starts a fresh symbol regardless of which state it came from
            if (pop) begin
                state      <= SYMBOL;
                data_out   <= mem[rd_ptr];
                carrier_en <= 1'b1;
                cnt        <= '0;
            end else if ((state == SYMBOL && !sym_last) || (state == GAP && !gap_last)) begin
                cnt <= cnt + 1'b1;
            end else if (state == SYMBOL && GAP_CYCLES > 0) begin
                state    <= GAP;
                data_out <= 8'h00;
                cnt      <= '0;
            end else begin
                state      <= IDLE;
                data_out   <= 8'h00;
                carrier_en <= 1'b0;
                cnt        <= '0;
            end
        end
    end
endmodule
